// File: rtl/ibex_instr_bus_arb.sv
// Two-port round-robin arbiter for the instruction memory port. Holds the
// chosen address until the memory grants it and routes responses in issue order.
module ibex_instr_bus_arb #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        req0_i,
  input  logic [31:0] addr0_i,
  output logic        gnt0_o,
  output logic        rvalid0_o,
  output logic [31:0] rdata0_o,
  output logic        err0_o,

  input  logic        req1_i,
  input  logic [31:0] addr1_i,
  output logic        gnt1_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata1_o,
  output logic        err1_o,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

  logic                      prio_q;
  logic                      lock_q;
  logic                      lock_id_q;
  logic [MaxOutstanding-1:0] id_q;
  logic [PtrW-1:0]           wr_ptr_q;
  logic [PtrW-1:0]           rd_ptr_q;
  logic [CntW-1:0]           count_q;

  logic sel;
  logic can_issue;
  logic grant;
  logic pop;
  logic head;
  logic fifo_empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // A pending (locked) request must be re-presented unchanged until granted.
  always_comb begin
    sel = prio_q;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (req0_i && !req1_i) begin
      sel = 1'b0;
    end else if (req1_i && !req0_i) begin
      sel = 1'b1;
    end
  end

  assign fifo_empty   = (count_q == '0);
  assign can_issue    = (count_q < CntMax) | instr_rvalid_i;
  assign instr_req_o  = can_issue & (req0_i | req1_i | lock_q);
  assign instr_addr_o = sel ? addr1_i : addr0_i;
  assign grant        = instr_req_o & instr_gnt_i;
  assign gnt0_o       = grant & ~sel;
  assign gnt1_o       = grant & sel;

  // A response arriving while nothing is outstanding is never routed.
  assign head      = id_q[rd_ptr_q];
  assign pop       = instr_rvalid_i & ~fifo_empty;
  assign rvalid0_o = pop & ~head;
  assign rvalid1_o = pop & head;
  assign rdata0_o  = instr_rdata_i;
  assign rdata1_o  = instr_rdata_i;
  assign err0_o    = instr_err_i & rvalid0_o;
  assign err1_o    = instr_err_i & rvalid1_o;
  assign busy_o    = ~fifo_empty | instr_req_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      id_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (grant) begin
        prio_q <= ~sel;
        lock_q <= 1'b0;
      end else if (instr_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (grant) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({grant, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(gnt0_o && gnt1_o));
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> !fifo_empty);
  a_err_with_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_err_i |-> instr_rvalid_i);
  a_addr_ok: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_req_o |-> (instr_addr_o[1:0] == 2'b00) && !$isunknown(instr_addr_o));
  a_lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (lock_id_q ? req1_i : req0_i));
  a_lock_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> instr_addr_o == $past(instr_addr_o));

endmodule

// File: tb/tb_ibex_instr_bus_arb.sv
// Bench for ibex_instr_bus_arb: directed cycle table, a reset corner sequence,
// and randomized traffic against a queue-based reference model.
module tb_ibex_instr_bus_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic [31:0] addr0_i = '0, addr1_i = '0;
  logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_instr_bus_arb #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_i(req0_i), .addr0_i(addr0_i), .gnt0_o(gnt0_o),
    .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o), .err0_o(err0_o),
    .req1_i(req1_i), .addr1_i(addr1_i), .gnt1_o(gnt1_o),
    .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o), .err1_o(err1_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .busy_o(busy_o)
  );

  typedef struct packed {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        e_g0;
    logic        e_g1;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v0;
    logic        e_v1;
    logic        e_e0;
    logic        e_e1;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1,
                       input logic [31:0] a1, input logic g, input logic rv,
                       input logic [31:0] rd, input logic er);
    req0_i = r0; addr0_i = a0; req1_i = r1; addr1_i = a1;
    instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
  endtask

  task automatic expect_out(input string tag, input logic g0, input logic g1, input logic rq,
                            input logic [31:0] ad, input logic v0, input logic v1,
                            input logic e0, input logic e1, input logic bz);
    chk({tag, ".gnt0"}, 32'(gnt0_o), 32'(g0));
    chk({tag, ".gnt1"}, 32'(gnt1_o), 32'(g1));
    chk({tag, ".req"}, 32'(instr_req_o), 32'(rq));
    if (rq) chk({tag, ".addr"}, instr_addr_o, ad);
    chk({tag, ".rvalid0"}, 32'(rvalid0_o), 32'(v0));
    chk({tag, ".rvalid1"}, 32'(rvalid1_o), 32'(v1));
    chk({tag, ".err0"}, 32'(err0_o), 32'(e0));
    chk({tag, ".err1"}, 32'(err1_o), 32'(e1));
    chk({tag, ".busy"}, 32'(busy_o), 32'(bz));
    chk({tag, ".rdata0"}, rdata0_o, instr_rdata_i);
    chk({tag, ".rdata1"}, rdata1_o, instr_rdata_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Reference model state for randomized traffic.
  int          q[$];
  int          lock_port;
  bit          prio_m;
  bit          preq[2];
  logic [31:0] paddr[2];

  initial begin
    // rst, r0,a0, r1,a1, gnt, rv,rd,er | g0,g1,req,addr, v0,v1,e0,e1,busy
    // single requester, response two cycles after grant
    vecs.push_back('{1, 1,32'h80, 0,0, 1, 0,0,0, 1,0,1,32'h80, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'hDEADBEEF,0, 0,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0});
    // both requesting: alternate 0,1,0,1
    vecs.push_back('{1, 1,32'h200, 1,32'h300, 1, 0,0,0, 1,0,1,32'h200, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h200, 1,32'h300, 1, 1,32'h1,0, 0,1,1,32'h300, 1,0,0,0,1});
    vecs.push_back('{0, 1,32'h200, 1,32'h300, 1, 1,32'h2,0, 1,0,1,32'h200, 0,1,0,0,1});
    vecs.push_back('{0, 1,32'h200, 1,32'h300, 1, 1,32'h3,0, 0,1,1,32'h300, 1,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'h4,0, 0,0,0,0, 0,1,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0});
    // port 1 locked while memory stalls, port 0 arrives later
    vecs.push_back('{0, 0,0, 1,32'h100, 0, 0,0,0, 0,0,1,32'h100, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h40, 1,32'h100, 0, 0,0,0, 0,0,1,32'h100, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h40, 1,32'h100, 0, 0,0,0, 0,0,1,32'h100, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h40, 1,32'h100, 1, 0,0,0, 0,1,1,32'h100, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h40, 0,0, 1, 0,0,0, 1,0,1,32'h40, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'h11,0, 0,0,0,0, 0,1,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'h22,0, 0,0,0,0, 1,0,0,0,1});
    // outstanding limit, retire and issue in the same cycle
    vecs.push_back('{0, 1,32'h10, 0,0, 1, 0,0,0, 1,0,1,32'h10, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 1,32'h14, 1, 0,0,0, 0,1,1,32'h14, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h18, 0,0, 1, 0,0,0, 0,0,0,0, 0,0,0,0,1});
    vecs.push_back('{0, 1,32'h18, 0,0, 1, 1,32'h33,0, 1,0,1,32'h18, 1,0,0,0,1});
    vecs.push_back('{0, 1,32'h1C, 0,0, 1, 0,0,0, 0,0,0,0, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'h44,0, 0,0,0,0, 0,1,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'h55,0, 0,0,0,0, 1,0,0,0,1});
    // interleaved 0,1,0 with an error on the port 1 response
    vecs.push_back('{0, 1,32'h20, 0,0, 1, 0,0,0, 1,0,1,32'h20, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 1,32'h24, 1, 0,0,0, 0,1,1,32'h24, 0,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'hA,0, 0,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0, 1,32'h28, 0,0, 1, 1,32'hB,1, 1,0,1,32'h28, 0,1,0,1,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 1,32'hC,0, 0,0,0,0, 1,0,0,0,1});
    vecs.push_back('{0, 0,0, 0,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0});

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      if (vecs[i].rst) begin
        do_reset();
      end
      drive(vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1,
            vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].er);
      #1;
      expect_out($sformatf("vec%0d", i), vecs[i].e_g0, vecs[i].e_g1, vecs[i].e_req,
                 vecs[i].e_addr, vecs[i].e_v0, vecs[i].e_v1, vecs[i].e_e0,
                 vecs[i].e_e1, vecs[i].e_busy);
    end

    // Reset in the middle of traffic: one outstanding, port 1 locked.
    @(negedge clk_i);
    do_reset();
    drive(1, 32'h80, 0, 0, 1, 0, 0, 0);
    #1 expect_out("rst.issue", 1, 0, 1, 32'h80, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 1, 32'h90, 0, 0, 0, 0);
    #1 expect_out("rst.stall", 0, 0, 1, 32'h90, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    #1 expect_out("rst.locked", 0, 0, 1, 32'h90, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 expect_out("rst.during", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst.addr", instr_addr_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1 expect_out("rst.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(1, 32'h300, 1, 32'h310, 1, 0, 0, 0);
    #1 expect_out("rst.prio0", 1, 0, 1, 32'h300, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 1, 32'h310, 1, 0, 0, 0);
    #1 expect_out("rst.second", 0, 1, 1, 32'h310, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(1, 32'h304, 0, 0, 1, 0, 0, 0);
    #1 expect_out("rst.full", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 1, 32'h66, 0);
    #1 expect_out("rst.resp0", 0, 0, 0, 0, 1, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 1, 32'h77, 0);
    #1 expect_out("rst.resp1", 0, 0, 0, 0, 0, 1, 0, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 expect_out("rst.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    @(negedge clk_i);
    do_reset();
    q.delete();
    lock_port = -1;
    prio_m = 1'b0;
    preq[0] = 1'b0; preq[1] = 1'b0;
    paddr[0] = '0;  paddr[1] = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      int          sel;
      bit          g, rv, er, ereq, can, hd;
      logic [31:0] rd;
      if (cyc != 0) @(negedge clk_i);
      for (int p = 0; p < 2; p++) begin
        if (!preq[p] && $urandom_range(0, 99) < 40) begin
          preq[p]  = 1'b1;
          paddr[p] = $urandom() & 32'hFFFF_FFFC;
        end
      end
      g  = ($urandom_range(0, 2) != 0);
      rv = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      er = rv && ($urandom_range(0, 3) == 0);
      rd = $urandom();
      drive(preq[0], paddr[0], preq[1], paddr[1], g, rv, rd, er);
      #1;
      if (lock_port >= 0) sel = lock_port;
      else if (preq[0] && !preq[1]) sel = 0;
      else if (preq[1] && !preq[0]) sel = 1;
      else sel = int'(prio_m);
      can  = (q.size() < 2) || rv;
      ereq = can && (preq[0] || preq[1]);
      hd   = rv ? q[0][0] : 1'b0;
      expect_out("rand", ereq && g && sel == 0, ereq && g && sel == 1, ereq, paddr[sel],
                 rv && !hd, rv && hd, er && !hd, er && hd, (q.size() != 0) || ereq);
      if (rv) void'(q.pop_front());
      if (ereq && g) begin
        q.push_back(sel);
        prio_m    = (sel == 0);
        lock_port = -1;
        preq[sel] = 1'b0;
      end else if (ereq) begin
        lock_port = sel;
      end
    end

    @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
